// File: rtl/dna_axil_slave_bridge.sv
// AXI4-Lite slave to simple memory-strobe bridge with independent write and read
// channel FSMs; every output is registered and the two FSM states are visible on debug ports.
module dna_axil_slave_bridge #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1,
   parameter int MEM_BYTES    = 4096
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [ADDR_WIDTH-1:0]   i_axi_awaddr,
   input  logic                    i_axi_awvalid,
   output logic                    o_axi_awready,
   input  logic [DATA_WIDTH-1:0]   i_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_axi_wstrb,
   input  logic                    i_axi_wvalid,
   output logic                    o_axi_wready,
   output logic [1:0]              o_axi_bresp,
   output logic                    o_axi_bvalid,
   input  logic                    i_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   i_axi_araddr,
   input  logic                    i_axi_arvalid,
   output logic                    o_axi_arready,
   output logic [DATA_WIDTH-1:0]   o_axi_rdata,
   output logic [1:0]              o_axi_rresp,
   output logic                    o_axi_rvalid,
   input  logic                    i_axi_rready,
   output logic [DATA_WIDTH/8-1:0] o_wen,
   output logic [ADDR_WIDTH-1:0]   o_addr_w,
   output logic [DATA_WIDTH-1:0]   o_data_w,
   output logic                    o_valid_w,
   output logic [ADDR_WIDTH-1:0]   o_addr_r,
   output logic                    o_valid_r,
   input  logic [DATA_WIDTH-1:0]   i_data_r,
   output logic [1:0]              o_dbg_w_state,
   output logic [1:0]              o_dbg_r_state
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = 2;
   localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_ISSUE = 2'd1, R_WAIT = 2'd2, R_RESP = 2'd3} r_state_t;

   // Valid/ready: a transfer happens at a rising edge where the sender's valid and the
   // receiver's ready are both 1; a sender keeps payload stable from valid until that edge.

   w_state_t                w_state_q, w_state_d;
   logic                    aw_held_q, aw_held_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic                    w_held_q, w_held_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic                    wr_err_q, wr_err_d;
   logic                    awready_q, awready_d;
   logic                    wready_q, wready_d;
   logic                    bvalid_q, bvalid_d;
   logic [1:0]              bresp_q, bresp_d;
   logic [STRB_W-1:0]       wen_q, wen_d;
   logic [ADDR_WIDTH-1:0]   addr_w_q, addr_w_d;
   logic [DATA_WIDTH-1:0]   data_w_q, data_w_d;
   logic                    valid_w_q, valid_w_d;
   logic                    wr_ok;

   r_state_t                r_state_q, r_state_d;
   logic                    rd_err_q, rd_err_d;
   logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
   logic                    arready_q, arready_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic                    rvalid_q, rvalid_d;
   logic [ADDR_WIDTH-1:0]   addr_r_q, addr_r_d;
   logic                    valid_r_q, valid_r_d;
   logic                    rd_ok;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} < MEM_LIMIT;
   endfunction

   always_comb begin
      w_state_d = w_state_q;
      aw_held_d = aw_held_q;
      awaddr_d  = awaddr_q;
      w_held_d  = w_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wr_err_d  = wr_err_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      addr_w_d  = addr_w_q;
      data_w_d  = data_w_q;
      wen_d     = '0;
      valid_w_d = 1'b0;
      wr_ok     = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (i_axi_awvalid && awready_q) begin
               aw_held_d = 1'b1;
               awaddr_d  = i_axi_awaddr;
            end
            if (i_axi_wvalid && wready_q) begin
               w_held_d = 1'b1;
               wdata_d  = i_axi_wdata;
               wstrb_d  = i_axi_wstrb;
            end
            // Commit straight from the handshake edge so the strobe lands one cycle later.
            if (aw_held_d && w_held_d) begin
               wr_ok     = in_range(awaddr_d);
               w_state_d = W_COMMIT;
               addr_w_d  = awaddr_d;
               data_w_d  = wdata_d;
               valid_w_d = wr_ok;
               wen_d     = wr_ok ? wstrb_d : '0;
               wr_err_d  = !wr_ok;
            end
         end
         W_COMMIT: begin
            w_state_d = W_RESP;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_err_q ? RESP_SLVERR : RESP_OKAY;
         end
         W_RESP: begin
            if (i_axi_bready) begin
               w_state_d = W_IDLE;
               bvalid_d  = 1'b0;
               bresp_d   = RESP_OKAY;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE) && !aw_held_d && !bvalid_d;
      wready_d  = (w_state_d == W_IDLE) && !w_held_d && !bvalid_d;
   end

   always_comb begin
      r_state_d = r_state_q;
      rd_err_d  = rd_err_q;
      rd_cnt_d  = rd_cnt_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rvalid_d  = rvalid_q;
      addr_r_d  = addr_r_q;
      valid_r_d = 1'b0;
      rd_ok     = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (i_axi_arvalid && arready_q) begin
               rd_ok     = in_range(i_axi_araddr);
               r_state_d = R_ISSUE;
               addr_r_d  = i_axi_araddr;
               valid_r_d = rd_ok;
               rd_err_d  = !rd_ok;
            end
         end
         R_ISSUE: begin
            r_state_d = R_WAIT;
            rd_cnt_d  = CNT_W'(READ_LATENCY - 1);
         end
         R_WAIT: begin
            // Count reaches zero on the edge where the slave's data is valid.
            if (rd_cnt_q == '0) begin
               r_state_d = R_RESP;
               rvalid_d  = 1'b1;
               rdata_d   = rd_err_q ? '0 : i_data_r;
               rresp_d   = rd_err_q ? RESP_SLVERR : RESP_OKAY;
            end else begin
               rd_cnt_d = rd_cnt_q - 1'b1;
            end
         end
         R_RESP: begin
            if (i_axi_rready) begin
               r_state_d = R_IDLE;
               rvalid_d  = 1'b0;
               rresp_d   = RESP_OKAY;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         w_state_q <= W_IDLE;
         aw_held_q <= 1'b0;
         awaddr_q  <= '0;
         w_held_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wr_err_q  <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         wen_q     <= '0;
         addr_w_q  <= '0;
         data_w_q  <= '0;
         valid_w_q <= 1'b0;
         r_state_q <= R_IDLE;
         rd_err_q  <= 1'b0;
         rd_cnt_q  <= '0;
         arready_q <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rvalid_q  <= 1'b0;
         addr_r_q  <= '0;
         valid_r_q <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         aw_held_q <= aw_held_d;
         awaddr_q  <= awaddr_d;
         w_held_q  <= w_held_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wr_err_q  <= wr_err_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         wen_q     <= wen_d;
         addr_w_q  <= addr_w_d;
         data_w_q  <= data_w_d;
         valid_w_q <= valid_w_d;
         r_state_q <= r_state_d;
         rd_err_q  <= rd_err_d;
         rd_cnt_q  <= rd_cnt_d;
         arready_q <= arready_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rvalid_q  <= rvalid_d;
         addr_r_q  <= addr_r_d;
         valid_r_q <= valid_r_d;
      end
   end

   assign o_axi_awready = awready_q;
   assign o_axi_wready  = wready_q;
   assign o_axi_bvalid  = bvalid_q;
   assign o_axi_bresp   = bresp_q;
   assign o_axi_arready = arready_q;
   assign o_axi_rdata   = rdata_q;
   assign o_axi_rresp   = rresp_q;
   assign o_axi_rvalid  = rvalid_q;
   assign o_wen         = wen_q;
   assign o_addr_w      = addr_w_q;
   assign o_data_w      = data_w_q;
   assign o_valid_w     = valid_w_q;
   assign o_addr_r      = addr_r_q;
   assign o_valid_r     = valid_r_q;
   assign o_dbg_w_state = w_state_q;
   assign o_dbg_r_state = r_state_q;

endmodule

// File: tb/tb_dna_axil_slave_bridge.sv
// Bench for dna_axil_slave_bridge: directed timing scenarios plus randomized traffic
// checked against a word-array memory model and an expected-read queue.
module tb_dna_axil_slave_bridge;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int SW    = DW / 8;
   localparam int RL    = 3;
   localparam int MEMB  = 4096;
   localparam int WORDS = MEMB / 4;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [AW-1:0] i_axi_awaddr = '0;
   logic          i_axi_awvalid = 1'b0;
   logic          o_axi_awready;
   logic [DW-1:0] i_axi_wdata = '0;
   logic [SW-1:0] i_axi_wstrb = '0;
   logic          i_axi_wvalid = 1'b0;
   logic          o_axi_wready;
   logic [1:0]    o_axi_bresp;
   logic          o_axi_bvalid;
   logic          i_axi_bready = 1'b0;
   logic [AW-1:0] i_axi_araddr = '0;
   logic          i_axi_arvalid = 1'b0;
   logic          o_axi_arready;
   logic [DW-1:0] o_axi_rdata;
   logic [1:0]    o_axi_rresp;
   logic          o_axi_rvalid;
   logic          i_axi_rready = 1'b0;
   logic [SW-1:0] o_wen;
   logic [AW-1:0] o_addr_w;
   logic [DW-1:0] o_data_w;
   logic          o_valid_w;
   logic [AW-1:0] o_addr_r;
   logic          o_valid_r;
   logic [DW-1:0] i_data_r;
   logic [1:0]    o_dbg_w_state;
   logic [1:0]    o_dbg_r_state;

   int checks = 0;
   int failures = 0;
   int wr_strobes = 0;
   int rd_strobes = 0;
   logic [DW-1:0] slave_mem [WORDS];
   logic [DW-1:0] ref_mem [WORDS];
   logic [DW-1:0] rd_pipe [RL];
   logic [DW-1:0] exp_q [$];

   always #5 clk = ~clk;

   dna_axil_slave_bridge #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .MEM_BYTES(MEMB)
   ) dut (
      .clk(clk), .resetn(resetn),
      .i_axi_awaddr(i_axi_awaddr), .i_axi_awvalid(i_axi_awvalid), .o_axi_awready(o_axi_awready),
      .i_axi_wdata(i_axi_wdata), .i_axi_wstrb(i_axi_wstrb), .i_axi_wvalid(i_axi_wvalid),
      .o_axi_wready(o_axi_wready),
      .o_axi_bresp(o_axi_bresp), .o_axi_bvalid(o_axi_bvalid), .i_axi_bready(i_axi_bready),
      .i_axi_araddr(i_axi_araddr), .i_axi_arvalid(i_axi_arvalid), .o_axi_arready(o_axi_arready),
      .o_axi_rdata(o_axi_rdata), .o_axi_rresp(o_axi_rresp), .o_axi_rvalid(o_axi_rvalid),
      .i_axi_rready(i_axi_rready),
      .o_wen(o_wen), .o_addr_w(o_addr_w), .o_data_w(o_data_w), .o_valid_w(o_valid_w),
      .o_addr_r(o_addr_r), .o_valid_r(o_valid_r), .i_data_r(i_data_r),
      .o_dbg_w_state(o_dbg_w_state), .o_dbg_r_state(o_dbg_r_state)
   );

   function automatic logic [DW-1:0] seed_word(input int i);
      return 32'h5A00_0000 ^ 32'(i * 65539);
   endfunction

   function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
      logic [DW-1:0] r;
      r = old_v;
      for (int b = 0; b < SW; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return 32'(MEMB) + 32'($urandom_range(0, 255));
      return 32'($urandom_range(0, MEMB - 1));
   endfunction

   // Memory slave: samples strobes mid-cycle, returns read data RL cycles after o_valid_r.
   initial begin
      logic          v_r, v_w;
      logic [AW-1:0] a_r, a_w;
      logic [DW-1:0] d_w;
      logic [SW-1:0] s_w;
      for (int i = 0; i < WORDS; i++) slave_mem[i] = seed_word(i);
      for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
      i_data_r = '0;
      forever begin
         @(negedge clk);
         v_r = o_valid_r; a_r = o_addr_r;
         v_w = o_valid_w; a_w = o_addr_w; d_w = o_data_w; s_w = o_wen;
         @(posedge clk);
         #1;
         if (v_w === 1'b1) begin
            slave_mem[a_w[11:2]] = apply_strb(slave_mem[a_w[11:2]], d_w, s_w);
            wr_strobes++;
         end
         for (int i = RL - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
         if (v_r === 1'b1) begin
            rd_pipe[0] = slave_mem[a_r[11:2]];
            rd_strobes++;
         end else begin
            rd_pipe[0] = $urandom;
         end
         i_data_r = rd_pipe[RL-1];
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog time_limit_reached required=finish");
      $fatal(1, "watchdog");
   end

   task automatic send_aw(input logic [AW-1:0] a, input int dly);
      int n; bit hs;
      repeat (dly) begin @(posedge clk); #1; end
      i_axi_awaddr = a; i_axi_awvalid = 1'b1;
      n = 0; hs = 0;
      while (!hs && n < 200) begin
         @(negedge clk); hs = (o_axi_awready === 1'b1);
         @(posedge clk); #1; n++;
      end
      i_axi_awvalid = 1'b0;
      checks++;
      if (!hs) begin failures++; $display("FAIL aw_handshake awready=%0b required=1", o_axi_awready); end
   endtask

   task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input int dly);
      int n; bit hs;
      repeat (dly) begin @(posedge clk); #1; end
      i_axi_wdata = d; i_axi_wstrb = s; i_axi_wvalid = 1'b1;
      n = 0; hs = 0;
      while (!hs && n < 200) begin
         @(negedge clk); hs = (o_axi_wready === 1'b1);
         @(posedge clk); #1; n++;
      end
      i_axi_wvalid = 1'b0;
      checks++;
      if (!hs) begin failures++; $display("FAIL w_handshake wready=%0b required=1", o_axi_wready); end
   endtask

   task automatic send_ar(input logic [AW-1:0] a, input int dly);
      int n; bit hs;
      repeat (dly) begin @(posedge clk); #1; end
      i_axi_araddr = a; i_axi_arvalid = 1'b1;
      n = 0; hs = 0;
      while (!hs && n < 200) begin
         @(negedge clk); hs = (o_axi_arready === 1'b1);
         @(posedge clk); #1; n++;
      end
      i_axi_arvalid = 1'b0;
      checks++;
      if (!hs) begin failures++; $display("FAIL ar_handshake arready=%0b required=1", o_axi_arready); end
   endtask

   task automatic recv_b(input int stall, output logic [1:0] resp);
      int n; bit seen, stable; logic [1:0] r0;
      n = 0; seen = 0; resp = 2'b11;
      while (!seen && n < 200) begin @(negedge clk); seen = (o_axi_bvalid === 1'b1); n++; end
      checks++;
      if (!seen) begin
         failures++; $display("FAIL b_timeout bvalid=%0b required=1", o_axi_bvalid);
         return;
      end
      r0 = o_axi_bresp; stable = 1;
      repeat (stall) begin
         @(negedge clk);
         if (o_axi_bvalid !== 1'b1 || o_axi_bresp !== r0 || o_axi_awready !== 1'b0) stable = 0;
      end
      checks++;
      if (!stable) begin failures++; $display("FAIL b_stable bresp=%b required=%b held", o_axi_bresp, r0); end
      i_axi_bready = 1'b1;
      @(posedge clk); #1;
      i_axi_bready = 1'b0;
      resp = r0;
   endtask

   task automatic recv_r(input int stall, output logic [DW-1:0] data, output logic [1:0] resp);
      int n; bit seen, stable; logic [1:0] r0; logic [DW-1:0] d0;
      n = 0; seen = 0; resp = 2'b11; data = 'x;
      while (!seen && n < 200) begin @(negedge clk); seen = (o_axi_rvalid === 1'b1); n++; end
      checks++;
      if (!seen) begin
         failures++; $display("FAIL r_timeout rvalid=%0b required=1", o_axi_rvalid);
         return;
      end
      r0 = o_axi_rresp; d0 = o_axi_rdata; stable = 1;
      repeat (stall) begin
         @(negedge clk);
         if (o_axi_rvalid !== 1'b1 || o_axi_rresp !== r0 || o_axi_rdata !== d0 ||
             o_axi_arready !== 1'b0) stable = 0;
      end
      checks++;
      if (!stable) begin failures++; $display("FAIL r_stable rdata=%h required=%h held", o_axi_rdata, d0); end
      i_axi_rready = 1'b1;
      @(posedge clk); #1;
      i_axi_rready = 1'b0;
      data = d0; resp = r0;
   endtask

   task automatic write_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input int awd, input int wd, input int stall, output logic [1:0] resp);
      fork
         send_aw(a, awd);
         send_w(d, s, wd);
      join
      recv_b(stall, resp);
   endtask

   task automatic read_txn(input logic [AW-1:0] a, input int ard, input int stall,
                           output logic [DW-1:0] data, output logic [1:0] resp);
      send_ar(a, ard);
      recv_r(stall, data, resp);
   endtask

   task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      if (a < MEMB) ref_mem[a[11:2]] = apply_strb(ref_mem[a[11:2]], d, s);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({o_axi_awready, o_axi_wready, o_axi_arready} !== 3'b000) begin
         failures++; $display("FAIL reset_readies got=%b required=000", {o_axi_awready, o_axi_wready, o_axi_arready});
      end
      checks++;
      if ({o_axi_bvalid, o_axi_rvalid, o_valid_w, o_valid_r} !== 4'b0000) begin
         failures++; $display("FAIL reset_valids got=%b required=0000", {o_axi_bvalid, o_axi_rvalid, o_valid_w, o_valid_r});
      end
      checks++;
      if ({o_wen, o_addr_w, o_data_w, o_addr_r, o_axi_rdata, o_axi_bresp, o_axi_rresp} !== '0) begin
         failures++; $display("FAIL reset_payload wen=%h addr_w=%h addr_r=%h rdata=%h required=0",
                              o_wen, o_addr_w, o_addr_r, o_axi_rdata);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({o_axi_awready, o_axi_wready, o_axi_arready} !== 3'b111) begin
         failures++; $display("FAIL release_readies got=%b required=111", {o_axi_awready, o_axi_wready, o_axi_arready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_write_same_cycle();
      int w0;
      w0 = wr_strobes;
      i_axi_bready = 1'b1;
      i_axi_awaddr = 32'h10; i_axi_awvalid = 1'b1;
      i_axi_wdata = 32'hDEAD_BEEF; i_axi_wstrb = 4'hF; i_axi_wvalid = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_axi_awready, o_axi_wready} !== 2'b11) begin
         failures++; $display("FAIL wsc_readies got=%b required=11", {o_axi_awready, o_axi_wready});
      end
      @(posedge clk); #1;
      i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (o_valid_w !== 1'b1 || o_addr_w !== 32'h10 || o_wen !== 4'hF ||
          o_data_w !== 32'hDEAD_BEEF || o_axi_bvalid !== 1'b0) begin
         failures++; $display("FAIL wsc_strobe valid_w=%0b addr=%h wen=%h data=%h bvalid=%0b required=1/10/f/deadbeef/0",
                              o_valid_w, o_addr_w, o_wen, o_data_w, o_axi_bvalid);
      end
      @(negedge clk);
      checks++;
      if (o_valid_w !== 1'b0 || o_wen !== 4'h0 || o_axi_bvalid !== 1'b1 || o_axi_bresp !== 2'b00) begin
         failures++; $display("FAIL wsc_bresp valid_w=%0b wen=%h bvalid=%0b bresp=%b required=0/0/1/00",
                              o_valid_w, o_wen, o_axi_bvalid, o_axi_bresp);
      end
      @(posedge clk); #1;
      i_axi_bready = 1'b0;
      @(negedge clk);
      checks++;
      if (o_axi_bvalid !== 1'b0 || o_axi_awready !== 1'b1 || wr_strobes != w0 + 1) begin
         failures++; $display("FAIL wsc_done bvalid=%0b awready=%0b strobes=%0d required=0/1/%0d",
                              o_axi_bvalid, o_axi_awready, wr_strobes - w0, 1);
      end
      model_write(32'h10, 32'hDEAD_BEEF, 4'hF);
      @(posedge clk); #1;
   endtask

   task automatic test_w_before_aw();
      int w0; bit ok; logic [DW-1:0] d; logic [1:0] br;
      w0 = wr_strobes; d = $urandom;
      send_w(d, 4'h3, 0);
      ok = 1;
      repeat (3) begin
         @(negedge clk);
         if (o_axi_wready !== 1'b0 || o_valid_w !== 1'b0 || o_axi_awready !== 1'b1) ok = 0;
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL wfirst_hold wready=%0b valid_w=%0b required=0/0", o_axi_wready, o_valid_w); end
      @(posedge clk); #1;
      send_aw(32'h20, 0);
      @(negedge clk);
      checks++;
      if (o_valid_w !== 1'b1 || o_wen !== 4'h3 || o_addr_w !== 32'h20 || o_data_w !== d) begin
         failures++; $display("FAIL wfirst_strobe valid_w=%0b wen=%h addr=%h data=%h required=1/3/20/%h",
                              o_valid_w, o_wen, o_addr_w, o_data_w, d);
      end
      @(negedge clk);
      checks++;
      if (o_axi_wready !== 1'b0 || o_valid_w !== 1'b0) begin
         failures++; $display("FAIL wfirst_wready_b wready=%0b valid_w=%0b required=0/0", o_axi_wready, o_valid_w);
      end
      recv_b(2, br);
      checks++;
      if (br !== 2'b00) begin failures++; $display("FAIL wfirst_bresp got=%b required=00", br); end
      @(negedge clk);
      checks++;
      if (o_axi_wready !== 1'b1 || wr_strobes != w0 + 1) begin
         failures++; $display("FAIL wfirst_after wready=%0b strobes=%0d required=1/1", o_axi_wready, wr_strobes - w0);
      end
      model_write(32'h20, d, 4'h3);
      @(posedge clk); #1;
   endtask

   task automatic test_read_latency();
      logic [1:0] br; bit ok;
      write_txn(32'h40, 32'h1234_5678, 4'hF, 0, 0, 0, br);
      model_write(32'h40, 32'h1234_5678, 4'hF);
      send_ar(32'h40, 0);
      @(negedge clk);
      checks++;
      if (o_valid_r !== 1'b1 || o_addr_r !== 32'h40) begin
         failures++; $display("FAIL rlat_strobe valid_r=%0b addr_r=%h required=1/40", o_valid_r, o_addr_r);
      end
      ok = 1;
      repeat (RL) begin
         @(negedge clk);
         if (o_axi_rvalid !== 1'b0 || o_valid_r !== 1'b0 || o_axi_arready !== 1'b0) ok = 0;
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL rlat_wait rvalid=%0b arready=%0b required=0/0", o_axi_rvalid, o_axi_arready); end
      ok = 1;
      repeat (5) begin
         @(negedge clk);
         if (o_axi_rvalid !== 1'b1 || o_axi_rdata !== 32'h1234_5678 || o_axi_rresp !== 2'b00 ||
             o_axi_arready !== 1'b0) ok = 0;
      end
      checks++;
      if (!ok) begin
         failures++; $display("FAIL rlat_resp rvalid=%0b rdata=%h rresp=%b required=1/12345678/00",
                              o_axi_rvalid, o_axi_rdata, o_axi_rresp);
      end
      i_axi_rready = 1'b1;
      @(posedge clk); #1;
      i_axi_rready = 1'b0;
      @(negedge clk);
      checks++;
      if (o_axi_rvalid !== 1'b0 || o_axi_arready !== 1'b1) begin
         failures++; $display("FAIL rlat_done rvalid=%0b arready=%0b required=0/1", o_axi_rvalid, o_axi_arready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_out_of_range();
      int w0, r0; logic [1:0] br, rr; logic [DW-1:0] rd, d;
      w0 = wr_strobes; r0 = rd_strobes; d = $urandom;
      write_txn(32'h1000, d, 4'hF, 1, 0, 1, br);
      read_txn(32'h1000, 0, 1, rd, rr);
      checks++;
      if (br !== 2'b10 || rr !== 2'b10 || rd !== '0) begin
         failures++; $display("FAIL oor_resp bresp=%b rresp=%b rdata=%h required=10/10/0", br, rr, rd);
      end
      checks++;
      if (wr_strobes != w0 || rd_strobes != r0) begin
         failures++; $display("FAIL oor_strobes wr=%0d rd=%0d required=0/0", wr_strobes - w0, rd_strobes - r0);
      end
      write_txn(32'hFFF, d, 4'hF, 0, 2, 0, br);
      model_write(32'hFFF, d, 4'hF);
      read_txn(32'hFFF, 1, 0, rd, rr);
      checks++;
      if (br !== 2'b00 || rr !== 2'b00 || rd !== ref_mem[WORDS-1] || wr_strobes != w0 + 1 || rd_strobes != r0 + 1) begin
         failures++; $display("FAIL edge_fff bresp=%b rresp=%b rdata=%h required=00/00/%h",
                              br, rr, rd, ref_mem[WORDS-1]);
      end
   endtask

   task automatic test_concurrent();
      logic [1:0] br, rr; logic [DW-1:0] rd, d, exp_d;
      d = $urandom; exp_d = ref_mem[3];
      i_axi_awaddr = 32'h8; i_axi_awvalid = 1'b1;
      i_axi_wdata = d; i_axi_wstrb = 4'hF; i_axi_wvalid = 1'b1;
      i_axi_araddr = 32'hC; i_axi_arvalid = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_axi_awready, o_axi_wready, o_axi_arready} !== 3'b111) begin
         failures++; $display("FAIL conc_readies got=%b required=111", {o_axi_awready, o_axi_wready, o_axi_arready});
      end
      @(posedge clk); #1;
      i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0; i_axi_arvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (o_valid_w !== 1'b1 || o_valid_r !== 1'b1 || o_addr_w !== 32'h8 || o_addr_r !== 32'hC) begin
         failures++; $display("FAIL conc_strobes valid_w=%0b valid_r=%0b addr_w=%h addr_r=%h required=1/1/8/c",
                              o_valid_w, o_valid_r, o_addr_w, o_addr_r);
      end
      fork
         recv_b(1, br);
         recv_r(2, rd, rr);
      join
      model_write(32'h8, d, 4'hF);
      checks++;
      if (br !== 2'b00 || rr !== 2'b00 || rd !== exp_d) begin
         failures++; $display("FAIL conc_resp bresp=%b rresp=%b rdata=%h required=00/00/%h", br, rr, rd, exp_d);
      end
      read_txn(32'h8, 0, 0, rd, rr);
      checks++;
      if (rd !== ref_mem[2]) begin failures++; $display("FAIL conc_readback rdata=%h required=%h", rd, ref_mem[2]); end
   endtask

   task automatic test_random();
      int w0, r0, exp_w, exp_r;
      w0 = wr_strobes; r0 = rd_strobes; exp_w = 0; exp_r = 0;
      for (int it = 0; it < 40; it++) begin
         int op;
         logic [AW-1:0] wa, ra;
         logic [DW-1:0] wd, rd, exp_d;
         logic [SW-1:0] ws;
         logic [1:0] br, rr;
         op = $urandom_range(0, 2);
         wa = rand_addr(); ra = rand_addr();
         if (op == 2 && wa[AW-1:2] == ra[AW-1:2]) ra = ra ^ 32'h4;
         wd = $urandom; ws = SW'($urandom_range(1, 15));
         if (op != 0) exp_q.push_back((ra < MEMB) ? ref_mem[ra[11:2]] : '0);
         case (op)
            0: write_txn(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br);
            1: read_txn(ra, $urandom_range(0, 3), $urandom_range(0, 3), rd, rr);
            default: fork
               write_txn(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br);
               read_txn(ra, $urandom_range(0, 3), $urandom_range(0, 3), rd, rr);
            join
         endcase
         if (op != 1) begin
            checks++;
            if (br !== ((wa < MEMB) ? 2'b00 : 2'b10)) begin
               failures++; $display("FAIL rand_bresp it=%0d addr=%h got=%b", it, wa, br);
            end
            if (wa < MEMB) exp_w++;
            model_write(wa, wd, ws);
         end
         if (op != 0) begin
            exp_d = exp_q.pop_front();
            checks++;
            if (rr !== ((ra < MEMB) ? 2'b00 : 2'b10) || rd !== exp_d) begin
               failures++; $display("FAIL rand_read it=%0d addr=%h rdata=%h rresp=%b required=%h", it, ra, rd, rr, exp_d);
            end
            if (ra < MEMB) exp_r++;
         end
      end
      checks++;
      if (wr_strobes - w0 != exp_w || rd_strobes - r0 != exp_r) begin
         failures++; $display("FAIL rand_strobe_count wr=%0d rd=%0d required=%0d/%0d",
                              wr_strobes - w0, rd_strobes - r0, exp_w, exp_r);
      end
   endtask

   task automatic test_reset_mid();
      int n, w0, r0; bit seen, quiet; logic [DW-1:0] d;
      d = $urandom;
      fork
         send_aw(32'h30, 0);
         send_w(d, 4'hF, 0);
      join
      n = 0; seen = 0;
      while (!seen && n < 50) begin @(negedge clk); seen = (o_axi_bvalid === 1'b1); n++; end
      checks++;
      if (!seen) begin failures++; $display("FAIL mid_bvalid got=%0b required=1", o_axi_bvalid); end
      model_write(32'h30, d, 4'hF);
      @(posedge clk); #1;
      send_ar(32'h34, 0);
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({o_axi_bvalid, o_axi_rvalid, o_valid_w, o_valid_r, o_axi_awready, o_axi_wready, o_axi_arready} !== 7'b0) begin
         failures++; $display("FAIL mid_reset_outputs got=%b required=0000000",
                              {o_axi_bvalid, o_axi_rvalid, o_valid_w, o_valid_r, o_axi_awready, o_axi_wready, o_axi_arready});
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      w0 = wr_strobes; r0 = rd_strobes;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({o_axi_awready, o_axi_wready, o_axi_arready} !== 3'b111) begin
         failures++; $display("FAIL mid_release_readies got=%b required=111", {o_axi_awready, o_axi_wready, o_axi_arready});
      end
      quiet = 1;
      repeat (8) begin
         @(negedge clk);
         if ({o_axi_bvalid, o_axi_rvalid, o_valid_w, o_valid_r} !== 4'b0) quiet = 0;
      end
      checks++;
      if (!quiet || wr_strobes != w0 || rd_strobes != r0) begin
         failures++; $display("FAIL mid_abandon quiet=%0b wr=%0d rd=%0d required=1/0/0", quiet, wr_strobes - w0, rd_strobes - r0);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) ref_mem[i] = seed_word(i);
      test_reset();
      test_write_same_cycle();
      test_w_before_aw();
      test_read_latency();
      test_out_of_range();
      test_concurrent();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
